// File: rtl/freq_pkg.sv
// freq_pkg: range encodings, FSM states and thresholds shared by the frequency meter.
package freq_pkg;
    localparam logic [1:0] RANGE_1S    = 2'b00;
    localparam logic [1:0] RANGE_100MS = 2'b01;
    localparam logic [1:0] RANGE_10MS  = 2'b10;
    localparam logic [1:0] RANGE_AUTO  = 2'b11;
    localparam int FREQ_W = 28;
    localparam logic [FREQ_W-1:0] FREQ_MAX = '1;
    localparam logic [34:0] DISPLAY_MAX   = 35'd999_999;
    localparam logic [34:0] AUTO_HI_100MS = 35'd99_999;
    localparam logic [34:0] AUTO_LO_100MS = 35'd90_000;
    localparam logic [34:0] AUTO_HI_10MS  = 35'd9_999;
    localparam logic [34:0] AUTO_LO_10MS  = 35'd9_000;
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_LATCH, S_HOLD
    } state_e;
endpackage

// File: rtl/freq_scale.sv
// freq_scale: scales a gate count to Hz by 1/10/100 with saturation and over-range flag.
module freq_scale
    import freq_pkg::*;
#(
    parameter int CNT_W = 28
) (
    input  logic [CNT_W-1:0]  cnt,
    input  logic [1:0]        rng,
    input  logic              ovf,
    output logic [FREQ_W-1:0] freq,
    output logic              over
);
    logic [34:0] c;
    logic [34:0] s;
    always_comb begin
        c    = 35'(cnt);
        s    = rng == RANGE_100MS ? (c << 3) + (c << 1) :
               rng == RANGE_10MS  ? (c << 6) + (c << 5) + (c << 2) : c;
        freq = (ovf || s > 35'(FREQ_MAX)) ? FREQ_MAX : s[FREQ_W-1:0];
        over = ovf || s > DISPLAY_MAX;
    end
endmodule

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: gate-window sequencer that clears, gates and captures the edge counter and ranges the result.
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int CNT_W         = 28,
    parameter int SETTLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        range_sel,
    input  logic [CNT_W-1:0]  cnt_value,
    input  logic              cnt_ovf,
    output logic              cnt_clr,
    output logic              cnt_en,
    output logic [FREQ_W-1:0] freq_out,
    output logic              freq_valid,
    output logic [1:0]        range_cur,
    output logic              over_range,
    output logic              busy
);
    localparam int TW = $clog2(CLK_FREQ);
    localparam int WMAX = SETTLE_CYCLES > HOLD_CYCLES ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int WW = $clog2(WMAX + 1);
    localparam logic [TW-1:0] LOAD_1S    = TW'(CLK_FREQ - 1);
    localparam logic [TW-1:0] LOAD_100MS = TW'(CLK_FREQ / 10 - 1);
    localparam logic [TW-1:0] LOAD_10MS  = TW'(CLK_FREQ / 100 - 1);

    state_e            state_q, state_d;
    logic [TW-1:0]     gate_q, gate_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [1:0]        rng_q, rng_d, cur_q, cur_d, nxt;
    logic              auto_q, auto_d, over_q, over_d, valid_q, valid_d, over;
    logic [FREQ_W-1:0] freq_q, freq_d, scaled;
    logic [34:0]       c35;

    freq_scale #(.CNT_W(CNT_W)) u_scale (
        .cnt  (cnt_value),
        .rng  (rng_q),
        .ovf  (cnt_ovf),
        .freq (scaled),
        .over (over)
    );

    // Auto-range step decided from the raw count of the measurement just taken
    always_comb begin
        c35 = 35'(cnt_value);
        nxt = rng_q == RANGE_1S    ? (over ? RANGE_100MS : RANGE_1S) :
              rng_q == RANGE_100MS ? ((c35 > AUTO_HI_100MS || cnt_ovf) ? RANGE_10MS :
                                      c35 <= AUTO_LO_100MS ? RANGE_1S : RANGE_100MS) :
              (c35 <= AUTO_LO_10MS ? RANGE_100MS : RANGE_10MS);
    end

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        wait_d  = wait_q;
        rng_d   = rng_q;
        auto_d  = auto_q;
        cur_d   = cur_q;
        freq_d  = freq_q;
        over_d  = over_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: state_d = enable ? S_CLEAR : S_IDLE;
            S_CLEAR: begin
                auto_d  = range_sel == RANGE_AUTO;
                rng_d   = auto_d ? cur_q : range_sel;
                gate_d  = rng_d == RANGE_100MS ? LOAD_100MS :
                          rng_d == RANGE_10MS  ? LOAD_10MS : LOAD_1S;
                state_d = enable ? S_GATE : S_IDLE;
            end
            S_GATE: begin
                state_d = !enable ? S_IDLE : gate_q == '0 ? S_SETTLE : S_GATE;
                gate_d  = (enable && gate_q != '0) ? gate_q - 1'b1 : gate_q;
                wait_d  = WW'(SETTLE_CYCLES - 1);
            end
            S_SETTLE: begin
                state_d = !enable ? S_IDLE : wait_q == '0 ? S_LATCH : S_SETTLE;
                wait_d  = wait_q == '0 ? wait_q : wait_q - 1'b1;
            end
            S_LATCH: begin
                freq_d  = scaled;
                over_d  = over;
                cur_d   = auto_q ? nxt : rng_q;
                valid_d = 1'b1;
                wait_d  = WW'(HOLD_CYCLES - 1);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                state_d = wait_q != '0 ? S_HOLD : enable ? S_CLEAR : S_IDLE;
                wait_d  = wait_q == '0 ? wait_q : wait_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gate_q  <= '0;
            wait_q  <= '0;
            rng_q   <= RANGE_1S;
            auto_q  <= 1'b0;
            cur_q   <= RANGE_1S;
            freq_q  <= '0;
            over_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            wait_q  <= wait_d;
            rng_q   <= rng_d;
            auto_q  <= auto_d;
            cur_q   <= cur_d;
            freq_q  <= freq_d;
            over_q  <= over_d;
            valid_q <= valid_d;
        end
    end

    assign cnt_clr    = state_q == S_CLEAR;
    assign cnt_en     = state_q == S_GATE;
    assign busy       = state_q != S_IDLE;
    assign freq_out   = freq_q;
    assign freq_valid = valid_q;
    assign range_cur  = cur_q;
    assign over_range = over_q;
endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb_freq_gate_ctrl: randomized scoreboard bench against a spec-level model of the measurement sequencer.
module tb_freq_gate_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  range_sel = 2'b00;
    logic [27:0] cnt_value = '0;
    logic        cnt_ovf = 1'b0;
    logic        cnt_clr, cnt_en, freq_valid, over_range, busy;
    logic [27:0] freq_out;
    logic [1:0]  range_cur;

    typedef struct {
        longint f;
        bit     o;
        int     r;
        int     n;
    } exp_t;

    exp_t   q[$];
    exp_t   e;
    int     passed = 0;
    int     total = 0;
    int     en_cnt = 0;
    int     clr_cnt = 0;
    int     valid_seen = 0;
    int     model_range = 0;
    longint last_freq = 0;

    freq_gate_ctrl #(
        .CLK_FREQ(1000), .CNT_W(28), .SETTLE_CYCLES(4), .HOLD_CYCLES(10)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .range_sel(range_sel),
        .cnt_value(cnt_value), .cnt_ovf(cnt_ovf), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
        .freq_out(freq_out), .freq_valid(freq_valid), .range_cur(range_cur),
        .over_range(over_range), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops one expectation per freq_valid pulse
    always @(negedge clk) begin
        if (!busy) begin
            en_cnt = 0;
            clr_cnt = 0;
        end
        if (cnt_en) en_cnt++;
        if (cnt_clr) clr_cnt++;
        if (freq_valid) begin
            valid_seen++;
            if (q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = q.pop_front();
                chk("freq_out", freq_out, e.f);
                chk("over_range", over_range, e.o);
                chk("range_cur", range_cur, e.r);
                chk("gate_len", en_cnt, e.n);
                chk("clr_len", clr_cnt, 1);
            end
            en_cnt = 0;
            clr_cnt = 0;
        end
    end

    task automatic wait_valid();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (freq_valid) return;
        end
        chk("valid_timeout", 0, 1);
    endtask

    task automatic wait_sig(input string name, input bit want_en);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (want_en ? cnt_en : !busy) return;
        end
        chk(name, 0, 1);
    endtask

    task automatic measure(input logic [1:0] rs, input longint c, input bit ovf);
        exp_t   x;
        int     g;
        longint m, s;
        g   = rs == 2'b11 ? model_range : int'(rs);
        m   = g == 0 ? 1 : g == 1 ? 10 : 100;
        s   = c * m;
        x.f = ovf ? 268435455 : (s > 268435455 ? 268435455 : s);
        x.o = ovf || s > 999999;
        if (rs != 2'b11) x.r = g;
        else if (g == 0) x.r = x.o ? 1 : 0;
        else if (g == 1) x.r = (c > 99999 || ovf) ? 2 : (c <= 90000 ? 0 : 1);
        else x.r = c <= 9000 ? 1 : 2;
        x.n = 1000 / int'(m);
        model_range = x.r;
        last_freq = x.f;
        q.push_back(x);
        range_sel = rs;
        cnt_value = 28'(c);
        cnt_ovf = ovf;
        enable = 1'b1;
        wait_valid();
    endtask

    initial begin
        int vs;
        longint c;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {cnt_clr, cnt_en, freq_out, freq_valid, range_cur, over_range, busy}, 0);
        rst = 1'b1;
        @(negedge clk);
        measure(2'b00, 250, 0);
        measure(2'b01, 1234, 0);
        measure(2'b10, 20000, 0);
        measure(2'b00, 250, 0);
        measure(2'b11, 1200000, 0);
        measure(2'b11, 120000, 0);
        measure(2'b11, 5000, 0);
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0: c = longint'($urandom_range(0, 10000));
                1: c = longint'($urandom_range(80000, 120000));
                2: c = longint'($urandom_range(0, 2000000));
                default: c = longint'($urandom_range(0, 268435455));
            endcase
            measure(2'($urandom_range(0, 3)), c, $urandom_range(0, 7) == 0);
        end
        measure(2'b01, 5, 1);
        enable = 1'b0;
        wait_sig("idle_timeout", 1'b0);
        range_sel = 2'b00;
        enable = 1'b1;
        wait_sig("gate_timeout", 1'b1);
        repeat (499) @(negedge clk);
        enable = 1'b0;
        vs = valid_seen;
        @(negedge clk);
        chk("abort_cnt_en", cnt_en, 0);
        chk("abort_busy", busy, 0);
        repeat (50) @(negedge clk);
        chk("abort_no_valid", valid_seen, vs);
        chk("abort_freq_kept", freq_out, last_freq);
        chk("abort_range_kept", range_cur, model_range);
        enable = 1'b1;
        wait_sig("gate2_timeout", 1'b1);
        repeat (100) @(negedge clk);
        chk("pre_reset_freq", freq_out, last_freq);
        #2 rst = 1'b0;
        #1;
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_freq", freq_out, 0);
        chk("rst_range", range_cur, 0);
        chk("rst_over", over_range, 0);
        chk("rst_clr_valid", {cnt_clr, freq_valid}, 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/freq_gate_ctrl.md
# freq_gate_ctrl

Measurement sequencer for the frequency meter. It owns the gate window: it clears and enables the external edge counter for an exact number of clock cycles, then captures the count. It scales the count to Hz and selects the gate range, either fixed or automatic. It sits between the counter datapath and the BCD/7-segment display path, and drives the 28-bit `freq_out` that the display decoder consumes.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: clk cycles in the 1 s gate.
- `CNT_W`, default 28: width of the counter value.
- `SETTLE_CYCLES`, default 4: idle cycles after the gate, so the counter's input synchronizer drains.
- `HOLD_CYCLES`, default 1000: pause between measurements.

Ports:
- `clk`, in, 1: system clock. There is one clock domain.
- `rst`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: run continuous measurements while high.
- `range_sel`, in, 2: 00 = 1 s gate, 01 = 100 ms, 10 = 10 ms, 11 = auto.
- `cnt_value`, in, CNT_W: edge count from the counter.
- `cnt_ovf`, in, 1: counter wrapped during the gate (sticky until `cnt_clr`).
- `cnt_clr`, out, 1: synchronous clear to the counter.
- `cnt_en`, out, 1: count enable (the gate).
- `freq_out`, out, 28: last result in Hz.
- `freq_valid`, out, 1: one-cycle pulse when `freq_out` updates.
- `range_cur`, out, 2: gate range in use (00/01/10).
- `over_range`, out, 1: last result exceeds 999_999 Hz or the counter overflowed.
- `busy`, out, 1: FSM is not in IDLE.

## Operation
- The FSM has six states:
  - IDLE: all strobes are low. Go to CLEAR when `enable` = 1.
  - CLEAR: `cnt_clr` = 1 for exactly 1 cycle. Latch the gate range here. Go to GATE.
  - GATE: `cnt_en` = 1 for exactly N cycles, with N = CLK_FREQ, CLK_FREQ/10 or CLK_FREQ/100 by range. Go to SETTLE.
  - SETTLE: SETTLE_CYCLES cycles with `cnt_en` = 0. Go to LATCH.
  - LATCH: 1 cycle. Capture `cnt_value` and `cnt_ovf`, then compute the result. Go to HOLD.
  - HOLD: HOLD_CYCLES cycles. Go to CLEAR if `enable` = 1, else to IDLE.
- Scaling by range:
  - range 00: freq = count.
  - range 01: freq = count×10, built as (c<<3)+(c<<1).
  - range 10: freq = count×100, built as (c<<6)+(c<<5)+(c<<2).
  - Compute at 35 bits, then saturate to 28'hFFFFFFF.
  - If `cnt_ovf` = 1, freq_out = 28'hFFFFFFF.
- over_range = `cnt_ovf` OR scaled freq > 999_999. It updates together with `freq_out`.
- Auto mode (range_sel = 11) picks next range_cur from this measurement's count c:
  - range 00: if over_range, go to 01.
  - range 01: if c > 99_999 or `cnt_ovf`, go to 10; else if c ≤ 90_000, go to 00.
  - range 10: if c ≤ 9_000, go to 01; 10 is the floor, so over_range simply stays set.
  - Entering auto from a fixed range starts from the current `range_cur`.
- Fixed mode: range_cur = range_sel, sampled in CLEAR.
- `range_sel` changes at any other time take effect at the next CLEAR.

## Timing
- Reset (`rst` = 0) clears everything immediately, without a clock:
  - state goes to IDLE;
  - every output is 0, including `range_cur` = 00;
  - the gate timer is 0.
- Timeline of one measurement:
  - `cnt_clr` rises 1 cycle after `enable` is sampled high in IDLE.
  - `cnt_en` rises the cycle after `cnt_clr` and stays high for exactly N cycles.
  - `freq_out`, `over_range`, `range_cur` and the `freq_valid` pulse appear 1 cycle after LATCH, all in the same cycle.
  - Those outputs hold until the next update.
- `enable` low during CLEAR, GATE or SETTLE aborts the measurement:
  - the next cycle goes to IDLE with `cnt_en` = 0;
  - there is no `freq_valid` pulse;
  - `freq_out` keeps its previous value.
- `enable` low during LATCH does not abort: the result is still published, and HOLD then exits to IDLE.
- Gate timer arithmetic:
  - The timer is $clog2(CLK_FREQ) bits wide.
  - It loads N-1 and terminates at 0, with no off-by-one.
  - N is computed by integer division of the parameter.
- `busy` = 1 in every state except IDLE.

## Structure
- A shared package `freq_pkg` holds:
  - the range encodings RANGE_1S, RANGE_100MS, RANGE_10MS and RANGE_AUTO;
  - the FSM state enum;
  - DISPLAY_MAX = 999_999;
  - the auto-range thresholds 99_999, 90_000, 9_999 and 9_000.
- Sub-module `freq_scale`: combinational multiply by 1/10/100 with saturation and the over_range compare. It is reused by the display path.

## Test plan
Simulations use CLK_FREQ = 1000, SETTLE_CYCLES = 4, HOLD_CYCLES = 10.
- Range 00, `enable` = 1, `cnt_value` = 250:
  - `cnt_clr` is high for exactly 1 cycle;
  - `cnt_en` is high for exactly 1000 cycles;
  - freq_out = 250, a single `freq_valid` pulse, over_range = 0.
- Range 01, `cnt_value` = 1234: gate is 100 cycles, freq_out = 12_340.
- Range 10, `cnt_value` = 20_000: gate is 10 cycles, freq_out = 2_000_000, over_range = 1.
- Auto mode from range 00, using counts 1_200_000, then 120_000, then 5_000:
  - range_cur steps 00 → 01 → 10 → 01;
  - third freq_out = 500_000, over_range = 0.
- `enable` dropped at gate cycle 500:
  - `cnt_en` is low the next cycle and `busy` = 0;
  - no `freq_valid` pulse;
  - freq_out keeps its previous value.
- Two overflow/reset cases:
  - `cnt_ovf` = 1 in LATCH gives freq_out = 28'hFFFFFFF and over_range = 1.
  - `rst` asserted mid-gate zeroes every output before the next clock edge.
